// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if
//   Bundles the ID-stage issue/operand signals of pipe_scoreboard.
//   master: ID-stage side (drives issue info, raw RF data, in-flight results,
//           squash mask; receives stall, operands, forward hits, stall count).
//   slave : the scoreboard itself.
//   Signals:
//     id_valid, id_we, id_dst, id_is_load   instruction currently in ID
//     id_src, id_src_used                   per-read-port source register / used flag
//     rf_data                               raw register-file read data per port
//     stage_data                            result in flight per tracked stage
//     flush                                 per-entry squash
//     stall, opnd, fwd_hit, stall_cnt       scoreboard results
interface pipe_scoreboard_if #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int STAGES   = 3,
    parameter int RD_PORTS = 2
);
    logic                         id_valid;
    logic                         id_we;
    logic [REG_AW-1:0]            id_dst;
    logic                         id_is_load;
    logic [RD_PORTS*REG_AW-1:0]   id_src;
    logic [RD_PORTS-1:0]          id_src_used;
    logic [RD_PORTS*DATA_W-1:0]   rf_data;
    logic [STAGES*DATA_W-1:0]     stage_data;
    logic [STAGES-1:0]            flush;
    logic                         stall;
    logic [RD_PORTS*DATA_W-1:0]   opnd;
    logic [RD_PORTS-1:0]          fwd_hit;
    logic [15:0]                  stall_cnt;

    modport master (
        output id_valid, id_we, id_dst, id_is_load, id_src, id_src_used,
               rf_data, stage_data, flush,
        input  stall, opnd, fwd_hit, stall_cnt
    );

    modport slave (
        input  id_valid, id_we, id_dst, id_is_load, id_src, id_src_used,
               rf_data, stage_data, flush,
        output stall, opnd, fwd_hit, stall_cnt
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Hazard scoreboard and operand-forwarding unit for the in-order pipeline.
//   Tracks destination tags of instructions issued past ID (entry 0 = EX,
//   1 = MEM, 2 = WB, ...), requests ID stalls and selects operand data.
//   Ports:
//     clk  clock
//     rst  synchronous reset, active-low
//     bus  pipe_scoreboard_if.slave (issue info in, stall/opnd/fwd_hit/stall_cnt out)
//   Build option:
//     PIPE_SCOREBOARD_FWD_EN defined  : forward from youngest matching stage,
//                                       stall only on load-use in EX.
//     PIPE_SCOREBOARD_FWD_EN undefined: no forwarding, stall on any match until
//                                       the producer retires past the last stage.
module pipe_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int STAGES   = 3,
    parameter int RD_PORTS = 2
) (
    input  logic                clk,
    input  logic                rst,
    pipe_scoreboard_if.slave    bus
);

    logic [STAGES-1:0]          v_q, v_d;
    logic [STAGES-1:0]          we_q, we_d;
    logic [REG_AW-1:0]          dst_q [STAGES];
    logic [REG_AW-1:0]          dst_d [STAGES];
`ifdef PIPE_SCOREBOARD_FWD_EN
    logic [STAGES-1:0]          ld_q, ld_d;
    logic                       hit;
    logic                       hit_busy;
    logic [DATA_W-1:0]          hit_data;
`endif
    logic                       stall_c;
    logic [RD_PORTS*DATA_W-1:0] opnd_c;
    logic [RD_PORTS-1:0]        fwd_c;
    logic [15:0]                cnt_q;
    int unsigned                k;

    // Hazard lookup: stages are scanned oldest to youngest so the youngest
    // (lowest index) match is the one left standing after the loop.
    always_comb begin
        stall_c = 1'b0;
        opnd_c  = bus.rf_data;
        fwd_c   = '0;
        k       = 0;
`ifdef PIPE_SCOREBOARD_FWD_EN
        hit      = 1'b0;
        hit_busy = 1'b0;
        hit_data = '0;
`endif
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
`ifdef PIPE_SCOREBOARD_FWD_EN
            hit      = 1'b0;
            hit_busy = 1'b0;
            hit_data = '0;
`endif
            for (int unsigned i = 0; i < STAGES; i++) begin
                k = STAGES - 1 - i;
                if (bus.id_valid && bus.id_src_used[p] && v_q[k] && we_q[k] &&
                    dst_q[k] == bus.id_src[p*REG_AW +: REG_AW]) begin
`ifdef PIPE_SCOREBOARD_FWD_EN
                    hit      = 1'b1;
                    hit_busy = ld_q[k] && (k == 0);
                    hit_data = bus.stage_data[k*DATA_W +: DATA_W];
`else
                    stall_c = 1'b1;
`endif
                end
            end
`ifdef PIPE_SCOREBOARD_FWD_EN
            if (hit) begin
                fwd_c[p]                   = 1'b1;
                opnd_c[p*DATA_W +: DATA_W] = hit_data;
                if (hit_busy) begin
                    stall_c = 1'b1;
                end
            end
`endif
        end
    end

    // Tag shift: flush of entry k replaces what would be loaded there.
    always_comb begin
        v_d[0]   = bus.id_valid && !stall_c && !bus.flush[0];
        we_d[0]  = bus.id_we;
        dst_d[0] = bus.id_dst;
`ifdef PIPE_SCOREBOARD_FWD_EN
        ld_d[0]  = bus.id_is_load;
`endif
        for (int unsigned s = 1; s < STAGES; s++) begin
            v_d[s]   = v_q[s-1] && !bus.flush[s];
            we_d[s]  = we_q[s-1];
            dst_d[s] = dst_q[s-1];
`ifdef PIPE_SCOREBOARD_FWD_EN
            ld_d[s]  = ld_q[s-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q <= v_d;
            if (stall_c && cnt_q != '1) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // Payload fields are only meaningful while v is set, so they need no reset.
    always_ff @(posedge clk) begin
        we_q  <= we_d;
        dst_q <= dst_d;
`ifdef PIPE_SCOREBOARD_FWD_EN
        ld_q  <= ld_d;
`endif
    end

    assign bus.stall     = stall_c;
    assign bus.opnd      = opnd_c;
    assign bus.fwd_hit   = fwd_c;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NS = 3;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_scoreboard_if #(.DATA_W(DW), .REG_AW(AW), .STAGES(NS), .RD_PORTS(NP)) bus ();

    pipe_scoreboard #(.DATA_W(DW), .REG_AW(AW), .STAGES(NS), .RD_PORTS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit            v;
        bit            we;
        bit            ld;
        logic [AW-1:0] dst;
    } ent_t;

    typedef struct {
        logic           st;
        logic [NP*DW-1:0] op;
        logic [NP-1:0]  fh;
        logic [15:0]    cnt;
    } exp_t;

    ent_t        mdl [NS];
    int unsigned mdl_cnt;
    exp_t        exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    logic        obs_st;
    logic [31:0] obs_op;
    logic [1:0]  obs_fh;
    logic [15:0] obs_cnt;
    bit          st_dummy;
    logic [15:0] base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: search entries youngest first and stop at the first match.
    function automatic exp_t predict();
        exp_t e;
        int   found;
        e.st  = 1'b0;
        e.op  = bus.rf_data;
        e.fh  = '0;
        e.cnt = mdl_cnt[15:0];
        for (int p = 0; p < NP; p++) begin
            found = -1;
            if (bus.id_valid && bus.id_src_used[p]) begin
                for (int s = 0; s < NS; s++) begin
                    if (found < 0 && mdl[s].v && mdl[s].we &&
                        mdl[s].dst == bus.id_src[p*AW +: AW]) found = s;
                end
            end
            if (found >= 0) begin
`ifdef PIPE_SCOREBOARD_FWD_EN
                e.op[p*DW +: DW] = bus.stage_data[found*DW +: DW];
                e.fh[p] = 1'b1;
                if (mdl[found].ld && found == 0) e.st = 1'b1;
`else
                e.st = 1'b1;
`endif
            end
        end
        return e;
    endfunction

    task automatic step(input bit val, input bit we, input logic [3:0] dst, input bit ld,
                        input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                        input logic [2:0] fl, input bit rv, output bit st_o);
        exp_t e;
        exp_t got_e;
        bus.id_valid    = val;
        bus.id_we       = we;
        bus.id_dst      = dst;
        bus.id_is_load  = ld;
        bus.id_src      = {s1, s0};
        bus.id_src_used = used;
        bus.flush       = fl;
        rst             = rv;
        e = predict();
        exp_q.push_back(e);
        @(negedge clk);
        obs_st  = bus.stall;
        obs_op  = bus.opnd;
        obs_fh  = bus.fwd_hit;
        obs_cnt = bus.stall_cnt;
        got_e = exp_q.pop_front();
        check("stall", {31'd0, obs_st}, {31'd0, got_e.st});
        check("opnd", obs_op, got_e.op);
        check("fwd_hit", {30'd0, obs_fh}, {30'd0, got_e.fh});
        check("stall_cnt", {16'd0, obs_cnt}, {16'd0, got_e.cnt});
        st_o = got_e.st;
        @(posedge clk);
        if (!rv) begin
            for (int s = 0; s < NS; s++) mdl[s].v = 1'b0;
            mdl_cnt = 0;
        end else begin
            if (got_e.st && mdl_cnt < 32'hFFFF) mdl_cnt++;
            for (int s = NS - 1; s >= 1; s--) begin
                mdl[s] = mdl[s-1];
                if (fl[s]) mdl[s].v = 1'b0;
            end
            mdl[0].v   = val && !got_e.st && !fl[0];
            mdl[0].we  = we;
            mdl[0].ld  = ld;
            mdl[0].dst = dst;
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit st;
        repeat (n) step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00, 3'b000, 1'b1, st);
    endtask

    bit          p_val, p_we, p_ld, last_st;
    logic [3:0]  p_dst, p_s0, p_s1;
    logic [1:0]  p_used;
    logic [2:0]  r_fl;
    bit          r_rv;

    initial begin
        rst = 1'b0;
        bus.id_valid = 1'b0; bus.id_we = 1'b0; bus.id_dst = '0; bus.id_is_load = 1'b0;
        bus.id_src = '0; bus.id_src_used = '0; bus.flush = '0;
        bus.rf_data = {16'hAAAA, 16'h1111};
        bus.stage_data = {16'h0003, 16'h0002, 16'h0042};
        for (int s = 0; s < NS; s++) begin
            mdl[s].v = 1'b0; mdl[s].we = 1'b0; mdl[s].ld = 1'b0; mdl[s].dst = '0;
        end
        mdl_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // reset state
        idle(1);
        check("rst_stall", {31'd0, obs_st}, 32'd0);
        check("rst_cnt", {16'd0, obs_cnt}, 32'd0);

        // ADD R3 ; ADD R4,R3,R1
        step(1, 1, 4'd3, 0, 4'd0, 4'd0, 2'b00, 3'b000, 1, st_dummy);
        base = obs_cnt;
`ifdef PIPE_SCOREBOARD_FWD_EN
        step(1, 1, 4'd4, 0, 4'd3, 4'd1, 2'b11, 3'b000, 1, st_dummy);
        check("fwd_ex_stall", {31'd0, obs_st}, 32'd0);
        check("fwd_ex_hit", {31'd0, obs_fh[0]}, 32'd1);
        check("fwd_ex_opnd", {16'd0, obs_op[15:0]}, 32'h0042);
`else
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 4'd4, 0, 4'd3, 4'd1, 2'b11, 3'b000, 1, st_dummy);
            check("nofwd_stall", {31'd0, obs_st}, 32'd1);
        end
        step(1, 1, 4'd4, 0, 4'd3, 4'd1, 2'b11, 3'b000, 1, st_dummy);
        check("nofwd_release", {31'd0, obs_st}, 32'd0);
        check("nofwd_hit", {30'd0, obs_fh}, 32'd0);
        check("nofwd_opnd", obs_op, bus.rf_data);
        check("nofwd_cnt", {16'd0, obs_cnt - base}, 32'd3);
`endif
        idle(3);

        // LW R5 ; ADD R6,R5,R5 (load-use)
        bus.stage_data = {16'h7777, 16'hBEEF, 16'h5555};
        step(1, 1, 4'd5, 1, 4'd0, 4'd0, 2'b00, 3'b000, 1, st_dummy);
        base = obs_cnt;
        step(1, 1, 4'd6, 0, 4'd5, 4'd5, 2'b11, 3'b000, 1, st_dummy);
        check("lu_stall", {31'd0, obs_st}, 32'd1);
        step(1, 1, 4'd6, 0, 4'd5, 4'd5, 2'b11, 3'b000, 1, st_dummy);
`ifdef PIPE_SCOREBOARD_FWD_EN
        check("lu_release", {31'd0, obs_st}, 32'd0);
        check("lu_cnt", {16'd0, obs_cnt - base}, 32'd1);
        check("lu_hit", {30'd0, obs_fh}, 32'd3);
        check("lu_opnd", obs_op, 32'hBEEFBEEF);
`endif
        idle(4);

        // R2 in EX and MEM: youngest wins
        bus.stage_data = {16'h0003, 16'h0002, 16'h0001};
        step(1, 1, 4'd2, 0, 4'd0, 4'd0, 2'b00, 3'b000, 1, st_dummy);
        step(1, 1, 4'd2, 0, 4'd0, 4'd0, 2'b00, 3'b000, 1, st_dummy);
        step(1, 0, 4'd9, 0, 4'd2, 4'd0, 2'b01, 3'b000, 1, st_dummy);
`ifdef PIPE_SCOREBOARD_FWD_EN
        check("young_opnd", {16'd0, obs_op[15:0]}, 32'h0001);
        check("young_hit", {31'd0, obs_fh[0]}, 32'd1);
`endif
        idle(4);

        // ADD R7 squashed at issue, then read R7
        step(1, 1, 4'd7, 0, 4'd0, 4'd0, 2'b00, 3'b001, 1, st_dummy);
        step(1, 0, 4'd8, 0, 4'd7, 4'd0, 2'b01, 3'b000, 1, st_dummy);
        check("flush0_stall", {31'd0, obs_st}, 32'd0);
        check("flush0_hit", {30'd0, obs_fh}, 32'd0);
        check("flush0_opnd", obs_op, bus.rf_data);
        idle(3);
        // ADD R7 killed while moving into entry 1
        step(1, 1, 4'd7, 0, 4'd0, 4'd0, 2'b00, 3'b000, 1, st_dummy);
        step(0, 0, 4'd0, 0, 4'd0, 4'd0, 2'b00, 3'b010, 1, st_dummy);
        step(1, 0, 4'd8, 0, 4'd7, 4'd7, 2'b11, 3'b000, 1, st_dummy);
        check("flush1_stall", {31'd0, obs_st}, 32'd0);
        check("flush1_hit", {30'd0, obs_fh}, 32'd0);
        idle(3);

        // reset during load-use stall
        step(1, 1, 4'd5, 1, 4'd0, 4'd0, 2'b00, 3'b000, 1, st_dummy);
        step(1, 1, 4'd6, 0, 4'd5, 4'd5, 2'b11, 3'b000, 1, st_dummy);
        check("rstmid_pre", {31'd0, obs_st}, 32'd1);
        step(1, 1, 4'd6, 0, 4'd5, 4'd5, 2'b11, 3'b000, 0, st_dummy);
        step(1, 1, 4'd6, 0, 4'd5, 4'd5, 2'b11, 3'b000, 1, st_dummy);
        check("rstmid_stall", {31'd0, obs_st}, 32'd0);
        check("rstmid_cnt", {16'd0, obs_cnt}, 32'd0);
        check("rstmid_hit", {30'd0, obs_fh}, 32'd0);
        check("rstmid_opnd", obs_op, bus.rf_data);
        idle(3);

        // random traffic over a small register set; a stalled instruction is held
        last_st = 1'b0;
        p_val = 0; p_we = 0; p_ld = 0; p_dst = '0; p_s0 = '0; p_s1 = '0; p_used = '0;
        for (int i = 0; i < 400; i++) begin
            if (!last_st) begin
                p_val  = ($urandom_range(0, 3) != 0);
                p_we   = ($urandom_range(0, 3) != 0);
                p_ld   = ($urandom_range(0, 2) == 0);
                p_dst  = 4'($urandom_range(0, 3));
                p_s0   = 4'($urandom_range(0, 3));
                p_s1   = 4'($urandom_range(0, 3));
                p_used = 2'($urandom_range(0, 3));
            end
            r_fl = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            r_rv = ($urandom_range(0, 99) != 0);
            bus.rf_data    = 32'($urandom);
            bus.stage_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            step(p_val, p_we, p_dst, p_ld, p_s0, p_s1, p_used, r_fl, r_rv, last_st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
